// File: rtl/sched_pkg.sv
// Shared scheduler types: arbiter state encoding and the compute op codes
// also used by scheduler_hls.
package sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

  localparam logic [31:0] CMP_NOP        = 32'd0;
  localparam logic [31:0] CMP_ATT_SCORES = 32'd4;
  localparam logic [31:0] CMP_CONCAT     = 32'd9;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans from last_grant+1 upward with
// wrap and reports the first requesting head.
module rr_pick #(
  parameter int NUM_HEADS = 4,
  parameter int HEAD_W    = 3
) (
  input  logic [NUM_HEADS-1:0] req,
  input  logic [HEAD_W-1:0]    last_grant,
  output logic                 any_req,
  output logic [HEAD_W-1:0]    winner
);

  int idx;

  // The head just served is visited last, so a busy head cannot starve others.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int off = 1; off <= NUM_HEADS; off++) begin
      idx = (int'(last_grant) + off) % NUM_HEADS;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = HEAD_W'(idx);
      end
    end
  end

endmodule

// File: rtl/head_compute_arbiter.sv
// Shares one compute engine among NUM_HEADS head sequencers: round-robin
// grant, start/accept handshake, done routing and a watchdog on the wait.
module head_compute_arbiter
  import sched_pkg::*;
#(
  parameter int NUM_HEADS      = 4,
  parameter int OP_W           = 32,
  parameter int HEAD_W         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_HEADS-1:0]      req_valid,
  input  logic [NUM_HEADS*OP_W-1:0] req_op,
  output logic [NUM_HEADS-1:0]      req_ready,
  output logic [NUM_HEADS-1:0]      req_done,
  input  logic                      compute_ready,
  output logic                      compute_start,
  output logic [OP_W-1:0]           compute_op,
  output logic [HEAD_W-1:0]         compute_head,
  input  logic                      compute_done,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clr,
  output logic [15:0]               issue_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t           state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [HEAD_W-1:0]    head_q, head_d;
  logic [HEAD_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          issue_q, issue_d;
  logic                 err_q, err_d;
  logic [NUM_HEADS-1:0] done_q, done_d;
  logic [NUM_HEADS-1:0] head_onehot;
  logic                 pick_any;
  logic [HEAD_W-1:0]    pick_winner;

  rr_pick #(
    .NUM_HEADS (NUM_HEADS),
    .HEAD_W    (HEAD_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any_req    (pick_any),
    .winner     (pick_winner)
  );

  assign head_onehot = NUM_HEADS'(1) << head_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    head_d       = head_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    issue_d      = issue_q;
    err_d        = err_q & ~err_clr;
    done_d       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          op_d    = req_op[int'(pick_winner)*OP_W +: OP_W];
          head_d  = pick_winner;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (compute_ready) begin
          issue_d = issue_q + 16'd1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done on the limit cycle counts as a normal completion.
        if (compute_done || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (!compute_done) err_d = 1'b1;
          done_d       = head_onehot;
          last_grant_d = head_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      head_q       <= '0;
      last_grant_q <= HEAD_W'(NUM_HEADS - 1);
      cnt_q        <= '0;
      issue_q      <= '0;
      err_q        <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      head_q       <= head_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      issue_q      <= issue_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign compute_start = (state_q == S_ISSUE);
  assign req_ready     = (compute_start && compute_ready) ? head_onehot : '0;
  assign req_done      = done_q;
  assign compute_op    = op_q;
  assign compute_head  = head_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = err_q;
  assign issue_count   = issue_q;

endmodule
